xadc_drp_responder: RTL
=======================

Name: xadc_drp_responder

Overview:
- Synthesizable stand-in for the XADC hard macro's Dynamic Reconfiguration Port (DRP); it is the responder side of the DRP read/write protocol.
- Runs a free-running continuous-conversion timer and captures an externally supplied 12-bit sample into status register 0x12.
- Pulses EOC on each conversion and answers DRP reads and writes with fixed latency.
- Used in simulation and on targets without the Xilinx IP, so the existing ADC front-end logic runs unchanged.

Parameters:
- DRP_LATENCY, 4, cycles from denIn accepted to drdyOut pulse; legal range 2..15.
- CONV_CYCLES, 26, clock cycles per conversion; legal range 4..1023.
- SAMPLE_ADDR, 7'h12, DRP address returning the latest conversion result.

Ports:
- clkIn  input  1  DRP/system clock
- rstNIn  input  1  asynchronous active-low reset
- sampleIn  input  12  analog value to "convert"; sampled at end of conversion
- daddrIn  input  7  DRP address
- denIn  input  1  DRP enable, single-cycle strobe
- dweIn  input  1  DRP write enable, qualified by denIn
- diIn  input  16  DRP write data
- doOut  output  16  DRP read data
- drdyOut  output  1  DRP ready, one-cycle pulse
- busyOut  output  1  conversion in progress
- eocOut  output  1  end-of-conversion, one-cycle pulse
- channelOut  output  5  channel of the last conversion, constant 5'h12
- protoErrOut  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock, clkIn. Reset is asynchronous and active-low (rstNIn); all state is cleared on assertion.
- Reset values: doOut=0, drdyOut=0, busyOut=0, eocOut=0, channelOut=5'h12, protoErrOut=0, sample register=0, config registers=0, DRP FSM=IDLE, conversion counter=0.
- Conversion timer:
  - Counter counts 0..CONV_CYCLES-1 and wraps. It starts on the first edge after reset release.
  - busyOut=1 whenever the counter is not CONV_CYCLES-1, and 0 in that cycle.
  - On the edge where the counter wraps, the sample register loads {sampleIn,4'h0} and eocOut is registered high for exactly one cycle, coincident with the new register value.
  - Period is exactly CONV_CYCLES; the first eocOut occurs CONV_CYCLES edges after reset release.
- Register map:
  - SAMPLE_ADDR is read-only and returns the sample register.
  - 0x40-0x4F are 16 read/write config registers. They have no side effects; storage only.
  - All other addresses read 16'h0000 and ignore writes.
- DRP FSM, IDLE -> WAIT -> IDLE:
  - IDLE: denIn=1 latches daddrIn, dweIn and diIn, loads the latency counter with DRP_LATENCY-1, and moves to WAIT. This is cycle T.
  - WAIT: the counter decrements each cycle. At zero, drdyOut=1 for one cycle (cycle T+DRP_LATENCY) and the FSM returns to IDLE.
  - A new denIn is accepted in the same cycle drdyOut is high. That gives back-to-back throughput of one transaction per DRP_LATENCY cycles.
- Read: doOut is updated on the drdyOut edge with the addressed register value as it stood before that edge. If a sample update lands on that same edge, the old sample is returned. doOut holds its value until the next read completes.
- Write: the register updates on the drdyOut edge; doOut is unchanged.
- Protocol violation: denIn=1 while in WAIT (excluding the drdyOut cycle) is ignored. The in-flight transaction is unaffected, and protoErrOut sets and stays set until reset.
- Reset mid-transaction: the transaction is dropped with no drdyOut; a write in flight is not committed.
- Width: sampleIn is left-justified into bits [15:4]; bits [3:0] are always 0.

Test Plan:
- Reset then idle: hold sampleIn=12'hABC. Expect the first eocOut at edge 26 after release, busyOut low only in the cycle before each eocOut, and eocOut repeating every 26 cycles.
- Read sample: after the first eocOut, drive den with addr 0x12 and dwe=0. Expect drdyOut exactly 4 cycles later, doOut=16'hABC0, and channelOut=5'h12.
- Write/readback: write 16'h1234 to 0x41, then read 0x41. Expect drdyOut for each after 4 cycles and doOut=16'h1234. A write of 16'hFFFF to 0x12 leaves a subsequent read of 0x12 at the sample value. A read of 0x20 returns 16'h0000.
- Collision and chaining: wire eocOut to denIn with addr 0x12 (continuous read loop). Change sampleIn each period. Expect each drdyOut's doOut to equal the sample captured at the triggering eocOut. Separately, issue a read of 0x12 whose drdyOut edge coincides with an eocOut edge; expect the pre-update sample.
- Protocol error: assert den 2 cycles after a prior den (DRP_LATENCY=4). Expect a single drdyOut for the first request and protoErrOut=1, held until rstNIn is asserted.
- Reset mid-op: start a write of 16'h5555 to 0x40 and pulse rstNIn low 2 cycles later. Expect no drdyOut, and a read of 0x40 after reset returns 16'h0000.

Source files
------------

// File: rtl/xadc_drp_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : xadc_drp_responder_if
// Brief    : DRP bus bundle between an XADC-style responder and its master.
// Revision : 1.0 - initial release
// ============================================================================
interface xadc_drp_responder_if;
    logic [6:0]  daddrIn;
    logic        denIn;
    logic        dweIn;
    logic [15:0] diIn;
    logic [15:0] doOut;
    logic        drdyOut;

    modport master (
        output daddrIn, denIn, dweIn, diIn,
        input  doOut, drdyOut
    );

    modport slave (
        input  daddrIn, denIn, dweIn, diIn,
        output doOut, drdyOut
    );
endinterface
`default_nettype wire

// File: rtl/xadc_drp_responder.sv
`default_nettype none
// ============================================================================
// Module   : xadc_drp_responder
// Brief    : Synthesizable stand-in for the XADC DRP responder: free-running
//            conversion timer, sample capture into the status register, 16
//            scratch config registers and fixed-latency DRP read/write.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_drp_responder #(
    parameter int unsigned DRP_LATENCY = 4,
    parameter int unsigned CONV_CYCLES = 26,
    parameter logic [6:0]  SAMPLE_ADDR = 7'h12
) (
    input  wire                  clkIn,
    input  wire                  rstNIn,
    input  wire [11:0]           sampleIn,
    xadc_drp_responder_if.slave  drp,
    output logic                 busyOut,
    output logic                 eocOut,
    output logic [4:0]           channelOut,
    output logic                 protoErrOut
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } drpState_t;

    localparam logic [9:0] c_convLast = 10'(CONV_CYCLES - 1);
    localparam logic [3:0] c_latLoad  = 4'(DRP_LATENCY - 1);

    drpState_t   r_state;
    drpState_t   w_stateNext;
    logic [3:0]  r_latCnt;
    logic [3:0]  w_latCntNext;
    logic        w_accept;
    logic        w_done;
    logic        w_violation;

    logic [6:0]  r_addr;
    logic        r_we;
    logic [15:0] r_di;
    logic [15:0] r_do;
    logic        r_drdy;
    logic        r_protoErr;

    logic [9:0]  r_convCnt;
    logic [9:0]  w_convNext;
    logic        r_busy;
    logic        r_eoc;
    logic [15:0] r_sample;

    logic [15:0] r_cfg [16];
    logic [15:0] w_rdData;
    logic        w_cfgHit;

    // DRP FSM state and latency counter registers
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_state  <= IDLE;
            r_latCnt <= 4'd0;
        end else begin
            r_state  <= w_stateNext;
            r_latCnt <= w_latCntNext;
        end
    end

    // DRP FSM next state; the response cycle is spent back in IDLE so a new
    // request can be accepted alongside drdyOut
    always_comb begin
        w_stateNext  = r_state;
        w_latCntNext = r_latCnt;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_violation  = 1'b0;
        case (r_state)
            IDLE: begin
                if (drp.denIn) begin
                    w_accept     = 1'b1;
                    w_latCntNext = c_latLoad;
                    w_stateNext  = WAIT;
                end
            end
            WAIT: begin
                w_latCntNext = r_latCnt - 4'd1;
                w_violation  = drp.denIn;
                if (r_latCnt == 4'd1) begin
                    w_done      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Config window decode; the sample address wins if the two ever overlap
    assign w_cfgHit = (r_addr[6:4] == 3'b100) && (r_addr != SAMPLE_ADDR);

    // Read mux over the latched address, using pre-update register contents
    always_comb begin
        w_rdData = 16'h0000;
        if (r_addr == SAMPLE_ADDR) begin
            w_rdData = r_sample;
        end else if (w_cfgHit) begin
            w_rdData = r_cfg[r_addr[3:0]];
        end
    end

    // Request latch, read response, drdy pulse and sticky protocol error
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_addr     <= 7'd0;
            r_we       <= 1'b0;
            r_di       <= 16'h0000;
            r_do       <= 16'h0000;
            r_drdy     <= 1'b0;
            r_protoErr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= drp.daddrIn;
                r_we   <= drp.dweIn;
                r_di   <= drp.diIn;
            end
            r_drdy <= w_done;
            if (w_done && !r_we) begin
                r_do <= w_rdData;
            end
            if (w_violation) begin
                r_protoErr <= 1'b1;
            end
        end
    end

    // Config register storage, committed on the response edge
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            for (int i = 0; i < 16; i++) begin
                r_cfg[i] <= 16'h0000;
            end
        end else if (w_done && r_we && w_cfgHit) begin
            r_cfg[r_addr[3:0]] <= r_di;
        end
    end

    assign w_convNext = (r_convCnt == c_convLast) ? 10'd0 : r_convCnt + 10'd1;

    // Free-running conversion timer with sample capture on wrap
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            r_convCnt <= 10'd0;
            r_busy    <= 1'b0;
            r_eoc     <= 1'b0;
            r_sample  <= 16'h0000;
        end else begin
            r_convCnt <= w_convNext;
            r_busy    <= (w_convNext != c_convLast);
            r_eoc     <= (r_convCnt == c_convLast);
            if (r_convCnt == c_convLast) begin
                r_sample <= {sampleIn, 4'h0};
            end
        end
    end

    assign drp.doOut   = r_do;
    assign drp.drdyOut = r_drdy;
    assign busyOut     = r_busy;
    assign eocOut      = r_eoc;
    assign channelOut  = 5'h12;
    assign protoErrOut = r_protoErr;

endmodule
`default_nettype wire
